// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a streaming FFT: combinational pass-through in RUN, zero-fill FLUSH, output framing by i_fft_sync.
// Zero latency on the input path; o_in_ready drops outside RUN, and the source holds its sample until it is accepted.
module fft_frame_sequencer #(
  parameter int LGSIZE = 12,
  parameter int IWIDTH = 16,
  parameter int LGTMO  = LGSIZE + 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [15:0]         i_frames,
  input  logic                i_in_valid,
  input  logic [2*IWIDTH-1:0] i_in_data,
  output logic                o_in_ready,
  output logic                o_ce,
  output logic [2*IWIDTH-1:0] o_fft_data,
  output logic                o_fft_sync,
  input  logic                i_fft_sync,
  output logic                o_out_valid,
  output logic                o_out_first,
  output logic                o_out_last,
  output logic                o_busy,
  output logic                o_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [LGSIZE-1:0] IDX_LAST = '1;
  localparam logic [LGTMO-1:0]  TMO_LAST = '1;

  state_t            state_q, state_d;
  logic [15:0]       frames_q, frames_d;
  logic [LGSIZE-1:0] idx_q, idx_d;
  logic [15:0]       in_frm_q, in_frm_d;
  logic [LGSIZE-1:0] bin_q, bin_d;
  logic [15:0]       out_frm_q, out_frm_d;
  logic              out_act_q, out_act_d;
  logic              err_q, err_d;
  logic              stop_pend_q, stop_pend_d;
  logic [LGTMO-1:0]  tmo_q, tmo_d;
  logic              ce_dly_q;

  logic              frm_ok;
  logic              stop_now;
  logic [LGSIZE-1:0] eff_bin;

  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    idx_d       = idx_q;
    in_frm_d    = in_frm_q;
    bin_d       = bin_q;
    out_frm_d   = out_frm_q;
    out_act_d   = out_act_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    tmo_d       = tmo_q;
    stop_now    = 1'b0;
    o_in_ready  = 1'b0;
    o_ce        = 1'b0;
    o_fft_data  = '0;

    case (state_q)
      RUN: begin
        o_in_ready = 1'b1;
        o_ce       = i_in_valid;
        o_fft_data = i_in_data;
      end
      FLUSH:   o_ce = 1'b1;
      default: ;
    endcase

    o_fft_sync = o_ce && (idx_q == '0);
    o_busy     = (state_q != IDLE);
    o_err      = err_q;

    // A sync arriving where bin 0 was not expected realigns the bin counter.
    frm_ok      = (frames_q == 16'd0) || (out_frm_q < frames_q);
    eff_bin     = i_fft_sync ? '0 : bin_q;
    o_out_valid = o_busy && ce_dly_q && (out_act_q || i_fft_sync) && frm_ok;
    o_out_first = o_out_valid && i_fft_sync;
    o_out_last  = o_out_valid && (eff_bin == IDX_LAST);

    if (o_out_valid) begin
      bin_d = eff_bin + 1'b1;
      if (i_fft_sync) out_act_d = 1'b1;
    end
    if (o_out_last) out_frm_d = out_frm_q + 16'd1;

    if (o_ce) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_LAST) in_frm_d = in_frm_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d     = RUN;
          frames_d    = i_frames;
          idx_d       = '0;
          in_frm_d    = 16'd0;
          bin_d       = '0;
          out_frm_d   = 16'd0;
          out_act_d   = 1'b0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
          tmo_d       = '0;
        end
      end
      RUN: begin
        stop_now = i_stop || stop_pend_q;
        if (o_ce && (idx_q == IDX_LAST)) begin
          if (stop_now || ((frames_q != 16'd0) && (in_frm_q == frames_q - 16'd1))) begin
            state_d     = FLUSH;
            tmo_d       = '0;
            stop_pend_d = 1'b0;
            if (stop_now) frames_d = in_frm_q + 16'd1;
          end
        end else if (i_stop && !o_ce && (idx_q == '0)) begin
          // Stop on a frame boundary: nothing partial to finish.
          frames_d    = in_frm_q;
          stop_pend_d = 1'b0;
          tmo_d       = '0;
          state_d     = (in_frm_q == 16'd0) ? IDLE : FLUSH;
        end else if (i_stop) begin
          stop_pend_d = 1'b1;
        end
      end
      FLUSH: begin
        if (out_frm_d == frames_q) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) out_act_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      frames_q    <= 16'd0;
      idx_q       <= '0;
      in_frm_q    <= 16'd0;
      bin_q       <= '0;
      out_frm_q   <= 16'd0;
      out_act_q   <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      tmo_q       <= '0;
      ce_dly_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frames_q    <= frames_d;
      idx_q       <= idx_d;
      in_frm_q    <= in_frm_d;
      bin_q       <= bin_d;
      out_frm_q   <= out_frm_d;
      out_act_q   <= out_act_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      tmo_q       <= tmo_d;
      ce_dly_q    <= o_ce;
    end
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter LGSIZE, default 12, meaning log2 of the FFT frame length N (N=4096).
REQ-002 SHALL have parameter IWIDTH, default 16, meaning width of each real and imaginary sample component.
REQ-003 SHALL have parameter LGTMO, default LGSIZE+2, meaning log2 of the flush watchdog limit in o_ce cycles.
REQ-004 SHALL have the port i_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 SHALL have the port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the port i_start, input, 1 bit: one-cycle start request, ignored unless IDLE.
REQ-007 SHALL have the port i_stop, input, 1 bit: finish the current input frame, then flush.
REQ-008 SHALL have the port i_frames, input, 16 bits: number of frames to process, sampled at start; 0 means continuous.
REQ-009 SHALL have the port i_in_valid, input, 1 bit: source sample valid.
REQ-010 SHALL have the port i_in_data, input, 2*IWIDTH bits: source sample as {re, im}.
REQ-011 SHALL have the port o_in_ready, output, 1 bit: sequencer accepts a sample this cycle.
REQ-012 SHALL have the port o_ce, output, 1 bit: clock enable to the FFT pipeline.
REQ-013 SHALL have the port o_fft_data, output, 2*IWIDTH bits: sample to the FFT.
REQ-014 SHALL have the port o_fft_sync, output, 1 bit: marks sample index 0 of each frame fed to the FFT.
REQ-015 SHALL have the port i_fft_sync, input, 1 bit: FFT output sync, marks output bin 0.
REQ-016 SHALL have the port o_out_valid, output, 1 bit: FFT output this cycle belongs to a requested frame.
REQ-017 SHALL have the port o_out_first, output, 1 bit: output bin 0 of a frame.
REQ-018 SHALL have the port o_out_last, output, 1 bit: output bin N-1 of a frame.
REQ-019 SHALL have the port o_busy, output, 1 bit: state is not IDLE.
REQ-020 SHALL have the port o_err, output, 1 bit: sticky flush-timeout flag, cleared by i_start.

Function
REQ-021 SHALL implement a state machine with states IDLE, RUN and FLUSH.
REQ-022 SHALL move from IDLE to RUN on i_start, latching i_frames into frames_req and clearing the input sample index, input frame count, output bin count, output frame count and o_err.
REQ-023 SHALL, in RUN, drive o_in_ready=1, o_ce=i_in_valid, and o_fft_data=i_in_data (combinational pass-through).
REQ-024 SHALL drive o_fft_sync=o_ce whenever the input sample index is 0.
REQ-025 SHALL advance the input sample index modulo N on each o_ce; wrap from N-1 to 0 increments the input frame count.
REQ-026 SHALL leave RUN for FLUSH at the accepted sample with index N-1 when either: frames_req is nonzero and the input frame count is then equal to frames_req-1; or i_stop is asserted, or was latched pending, during the frame.
REQ-027 SHALL, on that transition, set frames_req to the completed input frame count when i_stop caused it.
REQ-028 SHALL, in FLUSH, drive o_in_ready=0, o_ce=1 every cycle and o_fft_data=0, and keep advancing the sample index and o_fft_sync as in RUN.
REQ-029 SHALL register ce_d as o_ce delayed by one cycle.
REQ-030 SHALL set o_out_valid = ce_d AND (out_active OR i_fft_sync) AND (frames_req==0 OR output frame count < frames_req).
REQ-031 SHALL set out_active on the first valid i_fft_sync; out_active is cleared only by reset or on return to IDLE.
REQ-032 SHALL set o_out_first = o_out_valid AND i_fft_sync.
REQ-033 SHALL advance the output bin count modulo N on each o_out_valid.
REQ-034 SHALL set o_out_last = o_out_valid AND (bin count == N-1); the output frame count increments at that edge.
REQ-035 SHALL leave FLUSH for IDLE on the edge where the output frame count reaches frames_req.
REQ-036 SHALL count o_ce cycles in FLUSH and, if the count reaches 2^LGTMO before REQ-035 is met, set o_err=1 and go to IDLE.
REQ-037 SHALL ignore i_start outside IDLE, and SHALL ignore i_stop in IDLE and FLUSH.
REQ-038 SHALL, when i_stop arrives in RUN and the input sample index is 0 with no sample accepted, go directly to FLUSH with frames_req = input frame count; if that count is 0, go to IDLE instead.
REQ-039 SHALL let i_fft_sync mismatching an expected bin 0 (out_active=1, bin count not 0) resynchronise the bin count to 0.

Reset
REQ-040 SHALL, while i_reset_n=0, asynchronously force: state to IDLE; all counters, out_active, ce_d and o_err to 0; o_in_ready, o_ce, o_fft_sync, o_out_valid, o_out_first, o_out_last and o_busy to 0; o_fft_data to 0.
REQ-041 SHALL leave the sequencer in IDLE with all outputs 0 after reset asserted mid-RUN or mid-FLUSH, and SHALL require a new i_start to restart.

Verification (LGSIZE=4, N=16, FFT model latency 40 ce)
REQ-042 Bench SHALL cover: i_frames=2, i_in_valid always 1 -> 32 o_ce in RUN, o_fft_sync at ce 0 and 16, then FLUSH; exactly 32 o_out_valid, o_out_first twice, o_out_last twice, then IDLE, o_err=0.
REQ-043 Bench SHALL cover: i_frames=1, i_in_valid toggling 1/0 -> o_ce equals i_in_valid in RUN; 16 outputs; flush o_ce contiguous.
REQ-044 Bench SHALL cover: i_frames=0, i_stop at accepted sample 5 of frame 3 -> RUN continues to sample 15; frames_req=4; exactly 64 valid outputs.
REQ-045 Bench SHALL cover: model never asserts i_fft_sync, i_frames=1 -> after 64 flush ce, o_err=1 and IDLE; next i_start clears o_err.
REQ-046 Bench SHALL cover: i_reset_n low at RUN sample 7 -> all outputs 0 immediately; i_start during RUN ignored, i_frames unchanged.
